// File: rtl/cdc_pkg.sv
// Shared definitions for the two-phase req/ack crossing source controller.
package cdc_pkg;

    // Controller states
    typedef enum logic [2:0] {
        FLUSH = 3'd0,
        IDLE  = 3'd1,
        SETUP = 3'd2,
        WAIT  = 3'd3,
        ERROR = 3'd4
    } state_t;

    // Depth of the ack synchroniser; FLUSH lasts this many cycles so the
    // synchroniser is fully refilled before its output is trusted.
    localparam int FLUSH_CYCLES = 2;

endpackage

// File: rtl/cdc_req_ack_tx_synch_ff.sv
// Plain multi-stage flop synchroniser for signals arriving from another clock
// domain. Deliberately has no reset: the owner flushes it by waiting.
module synch_ff #(
    parameter int WIDTH  = 1,
    parameter int STAGES = 2
) (
    input  logic             i_clk,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    logic [WIDTH-1:0] stage_r [STAGES];

    // Shift the asynchronous input through the synchroniser chain
    always_ff @(posedge i_clk) begin
        stage_r[0] <= i_d;
        for (int i = 1; i < STAGES; i++) begin
            stage_r[i] <= stage_r[i-1];
        end
    end

    assign o_q = stage_r[STAGES-1];

endmodule

// File: rtl/cdc_req_ack_tx.sv
// Source side of a bundled-data clock-domain crossing. Holds each accepted
// word on the crossing bus, toggles req, and waits for the far side's ack
// toggle (seen through a synchroniser) before accepting the next word.
module cdc_req_ack_tx
    import cdc_pkg::*;
#(
    parameter int WIDTH   = 8,
    parameter int TIMEOUT = 1024,
    parameter int CNT_W   = 16
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_valid,
    input  logic [WIDTH-1:0] i_data,
    output logic             o_ready,
    output logic [WIDTH-1:0] o_xfer_data,
    output logic             o_xfer_req,
    input  logic             i_xfer_ack,
    output logic             o_done,
    output logic             o_timeout,
    input  logic             i_clr_err,
    output logic [CNT_W-1:0] o_xfer_cnt
);

    localparam int TW = ($clog2(TIMEOUT) > 1) ? $clog2(TIMEOUT) : 1;
    localparam int FW = ($clog2(FLUSH_CYCLES) > 1) ? $clog2(FLUSH_CYCLES) : 1;
    localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT - 1);
    localparam logic [FW-1:0] FLUSH_LAST = FW'(FLUSH_CYCLES - 1);
    localparam bit            TO_EN      = (TIMEOUT != 0);

    state_t           state_r,     state_nx_s;
    logic [FW-1:0]    flush_cnt_r, flush_cnt_nx_s;
    logic [TW-1:0]    timer_r,     timer_nx_s;
    logic             req_r,       req_nx_s;
    logic [WIDTH-1:0] data_r,      data_nx_s;
    logic             done_r,      done_nx_s;
    logic             timeout_r,   timeout_nx_s;
    logic [CNT_W-1:0] cnt_r,       cnt_nx_s;
    logic             ready_r,     ready_nx_s;
    logic             ack_s;

    synch_ff #(
        .WIDTH  (1),
        .STAGES (FLUSH_CYCLES)
    ) u_ack_sync (
        .i_clk (i_clk),
        .i_d   (i_xfer_ack),
        .o_q   (ack_s)
    );

    // Next-state and next-output decode for the handshake controller
    always_comb begin
        state_nx_s     = state_r;
        flush_cnt_nx_s = flush_cnt_r;
        timer_nx_s     = timer_r;
        req_nx_s       = req_r;
        data_nx_s      = data_r;
        done_nx_s      = 1'b0;
        timeout_nx_s   = timeout_r;
        cnt_nx_s       = cnt_r;
        case (state_r)
            FLUSH: begin
                if (flush_cnt_r == FLUSH_LAST) begin
                    // Align req to whatever phase the far side currently holds
                    req_nx_s       = ack_s;
                    flush_cnt_nx_s = '0;
                    state_nx_s     = IDLE;
                end else begin
                    flush_cnt_nx_s = flush_cnt_r + FW'(1);
                end
            end
            IDLE: begin
                if (i_valid) begin
                    data_nx_s  = i_data;
                    state_nx_s = SETUP;
                end else begin
                    state_nx_s = IDLE;
                end
            end
            SETUP: begin
                // Data has now been stable for a cycle; move req
                req_nx_s   = ~req_r;
                timer_nx_s = '0;
                state_nx_s = WAIT;
            end
            WAIT: begin
                if (ack_s == req_r) begin
                    done_nx_s  = 1'b1;
                    cnt_nx_s   = cnt_r + CNT_W'(1);
                    state_nx_s = IDLE;
                end else if (TO_EN && (timer_r == TIMER_LAST)) begin
                    timeout_nx_s = 1'b1;
                    state_nx_s   = ERROR;
                end else if (TO_EN) begin
                    timer_nx_s = timer_r + TW'(1);
                end else begin
                    timer_nx_s = timer_r;
                end
            end
            ERROR: begin
                if (i_clr_err) begin
                    // Abandon the transfer and realign to the far side's phase
                    timeout_nx_s = 1'b0;
                    req_nx_s     = ack_s;
                    state_nx_s   = IDLE;
                end else begin
                    timeout_nx_s = 1'b1;
                end
            end
            default: begin
                state_nx_s = FLUSH;
            end
        endcase
        ready_nx_s = (state_nx_s == IDLE);
    end

    // State and output registers with synchronous reset
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_r     <= FLUSH;
            flush_cnt_r <= '0;
            timer_r     <= '0;
            req_r       <= 1'b0;
            data_r      <= '0;
            done_r      <= 1'b0;
            timeout_r   <= 1'b0;
            cnt_r       <= '0;
            ready_r     <= 1'b0;
        end else begin
            state_r     <= state_nx_s;
            flush_cnt_r <= flush_cnt_nx_s;
            timer_r     <= timer_nx_s;
            req_r       <= req_nx_s;
            data_r      <= data_nx_s;
            done_r      <= done_nx_s;
            timeout_r   <= timeout_nx_s;
            cnt_r       <= cnt_nx_s;
            ready_r     <= ready_nx_s;
        end
    end

    assign o_ready     = ready_r;
    assign o_xfer_data = data_r;
    assign o_xfer_req  = req_r;
    assign o_done      = done_r;
    assign o_timeout   = timeout_r;
    assign o_xfer_cnt  = cnt_r;

endmodule

// File: tb/tb_cdc_req_ack_tx.sv
// Directed testbench for cdc_req_ack_tx with TIMEOUT=16. Inputs change 1 ns
// after a rising edge; outputs are sampled at the same point, so "after
// tick t" means the register values produced by edge t.
module tb_cdc_req_ack_tx;

    logic        clk = 1'b0;
    logic        rst;
    logic        valid;
    logic [7:0]  data;
    logic        ready;
    logic [7:0]  xfer_data;
    logic        xfer_req;
    logic        xfer_ack;
    logic        done;
    logic        timeout;
    logic        clr_err;
    logic [15:0] xfer_cnt;
    logic        loop_en;
    logic        ack_man;

    int tests_run    = 0;
    int tests_failed = 0;

    assign xfer_ack = loop_en ? xfer_req : ack_man;

    cdc_req_ack_tx #(
        .WIDTH   (8),
        .TIMEOUT (16),
        .CNT_W   (16)
    ) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_valid     (valid),
        .i_data      (data),
        .o_ready     (ready),
        .o_xfer_data (xfer_data),
        .o_xfer_req  (xfer_req),
        .i_xfer_ack  (xfer_ack),
        .o_done      (done),
        .o_timeout   (timeout),
        .i_clr_err   (clr_err),
        .o_xfer_cnt  (xfer_cnt)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reset with ack held at ack_lvl, then leave the DUT in IDLE
    task automatic do_reset(input logic ack_lvl);
        loop_en = 1'b0;
        ack_man = ack_lvl;
        valid   = 1'b0;
        clr_err = 1'b0;
        data    = 8'h00;
        rst     = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
        repeat (2) tick();
    endtask

    task automatic test_reset();
        loop_en = 1'b0;
        ack_man = 1'b1;
        clr_err = 1'b0;
        valid   = 1'b1;
        data    = 8'h5A;
        rst     = 1'b1;
        repeat (3) tick();
        tests_run++;
        if ({ready, xfer_req, xfer_data, done, timeout, xfer_cnt} !== 28'h0) begin
            tests_failed++;
            $display("FAIL reset_values got rdy=%b req=%b data=%h done=%b to=%b cnt=%h exp all zero",
                     ready, xfer_req, xfer_data, done, timeout, xfer_cnt);
        end
        rst = 1'b0;
        tick();
        tests_run++;
        if (ready !== 1'b0) begin
            tests_failed++;
            $display("FAIL flush_ready1 got %b exp 0", ready);
        end
        tick();
        tests_run++;
        if ({ready, xfer_req} !== 2'b11) begin
            tests_failed++;
            $display("FAIL flush_exit got rdy=%b req=%b exp rdy=1 req=1", ready, xfer_req);
        end
        tick();
        tests_run++;
        if ({ready, xfer_data} !== {1'b0, 8'h5A}) begin
            tests_failed++;
            $display("FAIL first_accept got rdy=%b data=%h exp rdy=0 data=5a", ready, xfer_data);
        end
        valid   = 1'b0;
        loop_en = 1'b1;
        repeat (4) tick();
        tests_run++;
        if ({done, xfer_cnt} !== {1'b1, 16'd1}) begin
            tests_failed++;
            $display("FAIL reset_first_xfer got done=%b cnt=%0d exp done=1 cnt=1", done, xfer_cnt);
        end
    endtask

    // Accepts at edges 1, 6, 11; req toggles at 2, 7, 12; done after 5, 10, 15
    task automatic test_loopback();
        logic       e_done, e_req, e_rdy;
        logic [7:0] e_data;
        do_reset(1'b0);
        loop_en = 1'b1;
        valid   = 1'b1;
        data    = 8'h11;
        for (int t = 1; t <= 16; t++) begin
            tick();
            e_done = (t == 5) || (t == 10) || (t == 15);
            e_rdy  = (t == 5) || (t == 10) || (t >= 15);
            e_req  = ((t >= 2) && (t < 7)) || (t >= 12);
            e_data = (t <= 5) ? 8'h11 : ((t <= 10) ? 8'h22 : 8'h33);
            tests_run++;
            if ({done, ready, xfer_req, xfer_data} !== {e_done, e_rdy, e_req, e_data}) begin
                tests_failed++;
                $display("FAIL loopback t=%0d got done=%b rdy=%b req=%b data=%h exp done=%b rdy=%b req=%b data=%h",
                         t, done, ready, xfer_req, xfer_data, e_done, e_rdy, e_req, e_data);
            end
            if (t == 1) data = 8'h22;
            if (t == 6) data = 8'h33;
            if (t == 11) begin
                data  = 8'hEE;
                valid = 1'b0;
            end
        end
        tests_run++;
        if (xfer_cnt !== 16'd3) begin
            tests_failed++;
            $display("FAIL loopback_cnt got %0d exp 3", xfer_cnt);
        end
    endtask

    // Req toggles at edge 2, ack echoed before edge 13, match seen at edge 15
    task automatic test_slow_far_side();
        do_reset(1'b0);
        valid = 1'b1;
        data  = 8'hA5;
        for (int t = 1; t <= 16; t++) begin
            tick();
            if (t == 1) begin
                valid = 1'b0;
                data  = 8'h00;
            end
            if (t == 12) ack_man = 1'b1;
            tests_run++;
            if ({done, timeout, xfer_data} !== {(t == 15), 1'b0, 8'hA5}) begin
                tests_failed++;
                $display("FAIL slow t=%0d got done=%b to=%b data=%h exp done=%b to=0 data=a5",
                         t, done, timeout, xfer_data, (t == 15));
            end
        end
        tests_run++;
        if (xfer_cnt !== 16'd1) begin
            tests_failed++;
            $display("FAIL slow_cnt got %0d exp 1", xfer_cnt);
        end
    endtask

    // Req toggles at edge 2; timer hits 15 at edge 18 without ack -> ERROR
    task automatic test_timeout();
        do_reset(1'b0);
        valid = 1'b1;
        data  = 8'h3C;
        tick();
        data = 8'h99;
        for (int t = 2; t <= 20; t++) begin
            tick();
            tests_run++;
            if ({timeout, ready, done, xfer_data} !== {(t >= 18), 1'b0, 1'b0, 8'h3C}) begin
                tests_failed++;
                $display("FAIL timeout t=%0d got to=%b rdy=%b done=%b data=%h exp to=%b rdy=0 done=0 data=3c",
                         t, timeout, ready, done, xfer_data, (t >= 18));
            end
        end
        clr_err = 1'b1;
        valid   = 1'b0;
        tick();
        clr_err = 1'b0;
        tests_run++;
        if ({timeout, ready, done, xfer_req, xfer_cnt} !== {1'b0, 1'b1, 1'b0, 1'b0, 16'd0}) begin
            tests_failed++;
            $display("FAIL clr_err got to=%b rdy=%b done=%b req=%b cnt=%0d exp to=0 rdy=1 done=0 req=0 cnt=0",
                     timeout, ready, done, xfer_req, xfer_cnt);
        end
        loop_en = 1'b1;
        valid   = 1'b1;
        data    = 8'h77;
        tick();
        valid = 1'b0;
        repeat (4) tick();
        tests_run++;
        if ({done, xfer_data, xfer_cnt} !== {1'b1, 8'h77, 16'd1}) begin
            tests_failed++;
            $display("FAIL after_clr got done=%b data=%h cnt=%0d exp done=1 data=77 cnt=1",
                     done, xfer_data, xfer_cnt);
        end
    endtask

    // Ack reaches ack_s just in time for edge 18, where timer == 15
    task automatic test_race();
        do_reset(1'b0);
        valid = 1'b1;
        data  = 8'hC3;
        for (int t = 1; t <= 19; t++) begin
            tick();
            if (t == 1) valid = 1'b0;
            if (t == 15) ack_man = 1'b1;
            tests_run++;
            if ({done, timeout} !== {(t == 18), 1'b0}) begin
                tests_failed++;
                $display("FAIL race t=%0d got done=%b to=%b exp done=%b to=0", t, done, timeout, (t == 18));
            end
        end
        tests_run++;
        if ({ready, xfer_cnt} !== {1'b1, 16'd1}) begin
            tests_failed++;
            $display("FAIL race_end got rdy=%b cnt=%0d exp rdy=1 cnt=1", ready, xfer_cnt);
        end
    endtask

    task automatic test_mid_reset();
        do_reset(1'b0);
        loop_en = 1'b1;
        valid   = 1'b1;
        data    = 8'h42;
        tick();
        valid = 1'b0;
        repeat (4) tick();
        tests_run++;
        if (xfer_cnt !== 16'd1) begin
            tests_failed++;
            $display("FAIL mid_pre_cnt got %0d exp 1", xfer_cnt);
        end
        // req is now 1; hold ack at 1 so the next transfer stalls in WAIT
        loop_en = 1'b0;
        ack_man = 1'b1;
        valid   = 1'b1;
        data    = 8'h43;
        tick();
        valid = 1'b0;
        repeat (3) tick();
        rst = 1'b1;
        repeat (3) tick();
        tests_run++;
        if ({done, ready, xfer_req, xfer_cnt} !== {1'b0, 1'b0, 1'b0, 16'd0}) begin
            tests_failed++;
            $display("FAIL mid_in_reset got done=%b rdy=%b req=%b cnt=%0d exp done=0 rdy=0 req=0 cnt=0",
                     done, ready, xfer_req, xfer_cnt);
        end
        rst = 1'b0;
        tick();
        tests_run++;
        if ({done, ready} !== 2'b00) begin
            tests_failed++;
            $display("FAIL mid_flush got done=%b rdy=%b exp done=0 rdy=0", done, ready);
        end
        tick();
        tests_run++;
        if ({done, ready, xfer_req, xfer_cnt} !== {1'b0, 1'b1, 1'b1, 16'd0}) begin
            tests_failed++;
            $display("FAIL mid_realign got done=%b rdy=%b req=%b cnt=%0d exp done=0 rdy=1 req=1 cnt=0",
                     done, ready, xfer_req, xfer_cnt);
        end
    endtask

    initial begin
        rst     = 1'b1;
        valid   = 1'b0;
        data    = 8'h00;
        clr_err = 1'b0;
        loop_en = 1'b0;
        ack_man = 1'b0;
        test_reset();
        test_loopback();
        test_slow_far_side();
        test_timeout();
        test_race();
        test_mid_reset();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
